core_irq_ctrl: RTL and testbench

Memory-mapped interrupt controller that aggregates up to 32 peripheral interrupt sources into the single `irq` line consumed by the core's exception control stage. It provides per-source enable, per-source level/edge mode, software set/clear of edge sources, a global enable, and a priority-encoded active-source register for the handler. It sits on the peripheral bus next to the core. Its registered `irq` output connects directly to the core's `irq` input.

---
 rtl/core_irq_ctrl_if.sv | 25 ++
 rtl/core_irq_ctrl.sv | 141 ++++++++++++++
 tb/tb_core_irq_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/core_irq_ctrl_if.sv
// Peripheral-bus (Avalon-style) register port for core_irq_ctrl.
// The master drives strobes, address and write data; the slave returns registered read data.
interface core_irq_ctrl_if;
    logic [2:0]  avl_address;
    logic        avl_read;
    logic        avl_write;
    logic [31:0] avl_writedata;
    logic [31:0] avl_readdata;

    modport master (
        output avl_address,
        output avl_read,
        output avl_write,
        output avl_writedata,
        input  avl_readdata
    );

    modport slave (
        input  avl_address,
        input  avl_read,
        input  avl_write,
        input  avl_writedata,
        output avl_readdata
    );
endinterface

// File: rtl/core_irq_ctrl.sv
// Interrupt controller: up to 32 level/edge sources folded into one registered irq line.
// Define CORE_IRQ_SYNC_EN to capture irq_src through a two-flop synchronizer instead of one flop.
module core_irq_ctrl #(
    parameter int unsigned NUM_IRQ = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_src,
    core_irq_ctrl_if.slave     avl,
    output logic               irq
);

    localparam logic [2:0] AddrPending = 3'd0;
    localparam logic [2:0] AddrEnable  = 3'd1;
    localparam logic [2:0] AddrMode    = 3'd2;
    localparam logic [2:0] AddrSet     = 3'd3;
    localparam logic [2:0] AddrActive  = 3'd4;
    localparam logic [2:0] AddrMaster  = 3'd5;

    logic [NUM_IRQ-1:0] src_q, src_prev_q;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] enable_q, enable_d;
    logic [NUM_IRQ-1:0] mode_q, mode_d;
    logic               master_q, master_d;
    logic               irq_q, irq_d;
    logic [31:0]        readdata_q, readdata_d;

    logic [NUM_IRQ-1:0] wdata, w1c, w1s, rise, masked;
    logic [31:0]        pending_w, enable_w, mode_w, active_w;
    logic               act_valid;
    logic [4:0]         act_idx;
    logic               unused_wdata;

    assign unused_wdata = ^avl.avl_writedata;

`ifdef CORE_IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            src_q  <= '0;
        end else begin
            sync_q <= irq_src;
            src_q  <= sync_q;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q <= '0;
        end else begin
            src_q <= irq_src;
        end
    end
`endif

    always_comb begin
        wdata = avl.avl_writedata[NUM_IRQ-1:0];
        w1c   = (avl.avl_write && avl.avl_address == AddrPending) ? wdata : '0;
        w1s   = (avl.avl_write && avl.avl_address == AddrSet) ? wdata : '0;
        // src_prev_q resets to 0, so a source high at reset release counts as a rising edge.
        rise  = src_q & ~src_prev_q;

        // Mode in effect before this edge governs the update; set beats clear on edge sources.
        pending_d = (~mode_q & src_q) | (mode_q & ((pending_q & ~w1c) | rise | w1s));

        enable_d = enable_q;
        mode_d   = mode_q;
        master_d = master_q;
        if (avl.avl_write) begin
            case (avl.avl_address)
                AddrEnable: enable_d = wdata;
                AddrMode:   mode_d   = wdata;
                AddrMaster: master_d = avl.avl_writedata[0];
                default:    ;
            endcase
        end

        masked = pending_q & enable_q;
        irq_d  = master_q & (|masked);
    end

    // Lowest-numbered enabled pending source wins.
    always_comb begin
        act_valid = 1'b0;
        act_idx   = 5'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (masked[i]) begin
                act_valid = 1'b1;
                act_idx   = 5'(i);
            end
        end
        active_w = {act_valid, 26'd0, act_idx};
    end

    always_comb begin
        pending_w                = '0;
        enable_w                 = '0;
        mode_w                   = '0;
        pending_w[NUM_IRQ-1:0]   = pending_q;
        enable_w[NUM_IRQ-1:0]    = enable_q;
        mode_w[NUM_IRQ-1:0]      = mode_q;

        readdata_d = readdata_q;
        if (avl.avl_read) begin
            case (avl.avl_address)
                AddrPending: readdata_d = pending_w;
                AddrEnable:  readdata_d = enable_w;
                AddrMode:    readdata_d = mode_w;
                AddrActive:  readdata_d = active_w;
                AddrMaster:  readdata_d = {31'd0, master_q};
                default:     readdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_prev_q <= '0;
            pending_q  <= '0;
            enable_q   <= '0;
            mode_q     <= '0;
            master_q   <= 1'b0;
            irq_q      <= 1'b0;
            readdata_q <= '0;
        end else begin
            src_prev_q <= src_q;
            pending_q  <= pending_d;
            enable_q   <= enable_d;
            mode_q     <= mode_d;
            master_q   <= master_d;
            irq_q      <= irq_d;
            readdata_q <= readdata_d;
        end
    end

    assign irq              = irq_q;
    assign avl.avl_readdata = readdata_q;

endmodule

// File: tb/tb_core_irq_ctrl.sv
// Directed bench for core_irq_ctrl (default build, NUM_IRQ = 16).
// Register reads go through a scoreboard queue of expected values.
module tb_core_irq_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] irq_src;
    logic        irq;

    core_irq_ctrl_if bus ();

    core_irq_ctrl #(.NUM_IRQ(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .irq_src (irq_src),
        .avl     (bus),
        .irq     (irq)
    );

    int unsigned vectors;
    int unsigned miscompares;
    logic [31:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
        bus.avl_write     = 1'b1;
        bus.avl_address   = addr;
        bus.avl_writedata = data;
        @(negedge clk);
        bus.avl_write     = 1'b0;
        bus.avl_writedata = '0;
    endtask

    task automatic bus_read(input string tag, input logic [2:0] addr, input logic [31:0] exp);
        logic [31:0] e;
        bus.avl_read    = 1'b1;
        bus.avl_address = addr;
        exp_q.push_back(exp);
        @(negedge clk);
        bus.avl_read = 1'b0;
        e = exp_q.pop_front();
        check(tag, bus.avl_readdata, e);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        vectors           = 0;
        miscompares       = 0;
        rst_n             = 1'b0;
        irq_src           = '0;
        bus.avl_read      = 1'b0;
        bus.avl_write     = 1'b0;
        bus.avl_address   = '0;
        bus.avl_writedata = '0;
        cycles(3);
        rst_n = 1'b1;

        // Reset state
        for (int a = 0; a < 8; a++) begin
            bus_read("reset_reg", 3'(a), 32'h0);
            check("reset_irq", {31'd0, irq}, 32'h0);
        end

        // Register width and unmapped addresses
        bus_write(3'd1, 32'hFFFF_FFFF);
        bus_read("enable_width", 3'd1, 32'h0000_FFFF);
        bus_write(3'd6, 32'hFFFF_FFFF);
        bus_read("addr6", 3'd6, 32'h0);
        bus_write(3'd1, 32'h0);

        // Level source 2
        bus_write(3'd5, 32'h1);
        bus_write(3'd1, 32'h4);
        bus_write(3'd2, 32'h0);
        irq_src[2] = 1'b1;
        cycles(1);
        check("lvl_irq_k", {31'd0, irq}, 32'h0);
        cycles(1);
        check("lvl_irq_k1", {31'd0, irq}, 32'h0);
        cycles(1);
        check("lvl_irq_k2", {31'd0, irq}, 32'h1);
        bus_read("lvl_active", 3'd4, 32'h8000_0002);
        bus_write(3'd0, 32'h4);
        bus_read("lvl_w1c_ignored", 3'd0, 32'h4);
        irq_src[2] = 1'b0;
        cycles(2);
        check("lvl_fall_k1", {31'd0, irq}, 32'h1);
        cycles(1);
        check("lvl_fall_k2", {31'd0, irq}, 32'h0);
        bus_write(3'd1, 32'h0);

        // Edge source 0
        bus_write(3'd2, 32'h1);
        bus_write(3'd1, 32'h1);
        irq_src[0] = 1'b1;
        cycles(1);
        irq_src[0] = 1'b0;
        cycles(2);
        check("edge_irq", {31'd0, irq}, 32'h1);
        bus_read("edge_persist", 3'd0, 32'h1);
        bus_write(3'd0, 32'h1);
        check("edge_w1c_k", {31'd0, irq}, 32'h1);
        cycles(1);
        check("edge_w1c_k1", {31'd0, irq}, 32'h0);
        irq_src[0] = 1'b1;
        cycles(1);
        bus_write(3'd0, 32'h1);
        irq_src[0] = 1'b0;
        bus_read("edge_set_wins", 3'd0, 32'h1);
        bus_write(3'd0, 32'h1);
        bus_read("edge_cleared", 3'd0, 32'h0);

        // Priority between edge sources 3 and 7
        bus_write(3'd2, 32'h89);
        bus_write(3'd1, 32'h88);
        irq_src = 16'h0088;
        cycles(1);
        irq_src = 16'h0000;
        cycles(2);
        bus_read("prio_active3", 3'd4, 32'h8000_0003);
        bus_write(3'd0, 32'h8);
        bus_read("prio_active7", 3'd4, 32'h8000_0007);
        check("prio_irq_on", {31'd0, irq}, 32'h1);
        bus_write(3'd5, 32'h0);
        cycles(1);
        check("master_off_irq", {31'd0, irq}, 32'h0);
        bus_read("master_off_active", 3'd4, 32'h8000_0007);

        // SET register
        bus_write(3'd2, 32'h20);
        bus_write(3'd1, 32'h20);
        bus_write(3'd5, 32'h1);
        check("set_pre_irq", {31'd0, irq}, 32'h0);
        bus_write(3'd3, 32'h20);
        check("set_irq_k", {31'd0, irq}, 32'h0);
        cycles(1);
        check("set_irq_k1", {31'd0, irq}, 32'h1);
        bus_read("set_reads_zero", 3'd3, 32'h0);
        bus_write(3'd0, 32'h20);
        bus_write(3'd2, 32'h0);
        cycles(1);
        bus_write(3'd3, 32'h20);
        bus_read("set_level_ignored", 3'd0, 32'h0);

        // Async reset with irq high and an edge pending
        bus_write(3'd2, 32'h20);
        bus_write(3'd3, 32'h20);
        cycles(1);
        check("rst_pre_irq", {31'd0, irq}, 32'h1);
        bus_read("rst_pre_rdata", 3'd1, 32'h20);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_irq", {31'd0, irq}, 32'h0);
        check("rst_async_rdata", bus.avl_readdata, 32'h0);
        cycles(2);
        rst_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            bus_read("post_rst_reg", 3'(a), 32'h0);
        end
        check("post_rst_irq", {31'd0, irq}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
